// File: rtl/id_ex_skid_stage.sv
// ---------------------------------------------------------------------------
// id_ex_skid_stage
//
// ID/EX pipeline register sitting directly in front of the ALU. Holds the
// decoded operand bundle in a two-entry skid buffer (main entry M drives the
// ALU, skid entry S catches the word that was already in flight when EX
// stalled), so decode never loses a word under backpressure. A taken branch
// (flush) empties both entries.
//
// Optional feature macro: FORWARD_EN
//   When defined, a writeback (fwd_we/fwd_addr/fwd_data) patches the rs/rt
//   contents of every valid held entry, and of a word being accepted in the
//   same cycle, whose register number matches. Register 0 is never forwarded.
//   When undefined, the fwd_* ports are present but ignored.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   in_valid/in_ready upstream handshake (in_ready registered, = !S.valid)
//   in_*              decoded fields plus rs/rt register numbers
//   flush             branch taken: discard everything held and offered
//   fwd_we/addr/data  writeback bus used for operand forwarding
//   out_valid/ready   downstream (ALU) handshake
//   out_*             head-entry fields presented to the ALU
// ---------------------------------------------------------------------------
module id_ex_skid_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [DATA_W-1:0] in_rs_content,
    input  logic [DATA_W-1:0] in_rt_content,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_alu_control,
    input  logic [15:0]       in_immediate,
    input  logic [REG_AW-1:0] in_rs_addr,
    input  logic [REG_AW-1:0] in_rt_addr,

    input  logic              flush,

    input  logic              fwd_we,
    input  logic [REG_AW-1:0] fwd_addr,
    input  logic [DATA_W-1:0] fwd_data,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        out_opcode,
    output logic [DATA_W-1:0] out_rs_content,
    output logic [DATA_W-1:0] out_rt_content,
    output logic [4:0]        out_shamt,
    output logic [5:0]        out_alu_control,
    output logic [15:0]       out_immediate
);

    typedef struct packed {
        logic [5:0]        opcode;
        logic [DATA_W-1:0] rs_content;
        logic [DATA_W-1:0] rt_content;
        logic [4:0]        shamt;
        logic [5:0]        alu_control;
        logic [15:0]       immediate;
        logic [REG_AW-1:0] rs_addr;
        logic [REG_AW-1:0] rt_addr;
    } bundle_t;

    bundle_t m_q, s_q;          // stored entries
    bundle_t m_d, s_d;          // next-state entries
    bundle_t in_raw, in_word;   // offered word before / after forwarding
    bundle_t m_held, s_held;    // held entries after forwarding
    logic    m_valid_q, s_valid_q;
    logic    m_valid_d, s_valid_d;
    logic    accept, consume;

    always_comb begin
        in_raw             = '0;
        in_raw.opcode      = in_opcode;
        in_raw.rs_content  = in_rs_content;
        in_raw.rt_content  = in_rt_content;
        in_raw.shamt       = in_shamt;
        in_raw.alu_control = in_alu_control;
        in_raw.immediate   = in_immediate;
        in_raw.rs_addr     = in_rs_addr;
        in_raw.rt_addr     = in_rt_addr;
    end

`ifdef FORWARD_EN
    // Replace rs/rt contents whose register number matches the writeback.
    // Both operands are patched independently; r0 is hardwired and skipped.
    function automatic bundle_t apply_fwd(
        input bundle_t           b,
        input logic              we,
        input logic [REG_AW-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        bundle_t r;
        r = b;
        if (we && (addr != '0)) begin
            if (b.rs_addr == addr) r.rs_content = data;
            if (b.rt_addr == addr) r.rt_content = data;
        end
        return r;
    endfunction

    assign in_word = apply_fwd(in_raw, fwd_we, fwd_addr, fwd_data);
    // Only valid entries are patched; an empty slot keeps its stale data.
    assign m_held  = m_valid_q ? apply_fwd(m_q, fwd_we, fwd_addr, fwd_data) : m_q;
    assign s_held  = s_valid_q ? apply_fwd(s_q, fwd_we, fwd_addr, fwd_data) : s_q;
`else
    assign in_word = in_raw;
    assign m_held  = m_q;
    assign s_held  = s_q;

    logic unused_fwd;
    assign unused_fwd = ^{fwd_we, fwd_addr, fwd_data};
`endif

    assign accept  = in_valid & in_ready;
    assign consume = m_valid_q & out_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        m_d       = m_held;
        s_d       = s_held;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;

        if (flush) begin
            // Branch taken: the head may still be consumed this cycle, but
            // nothing survives into the next one and the offered word is lost.
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q) begin
            // S is never occupied while M is empty, so M is the only target.
            if (accept) begin
                m_d       = in_word;
                m_valid_d = 1'b1;
            end
        end else if (consume) begin
            if (s_valid_q) begin
                // in_ready was low, so no accept can collide with this move.
                m_d       = s_held;
                s_valid_d = 1'b0;
            end else if (accept) begin
                m_d = in_word;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            // EX stalled with M full: the in-flight word parks in S.
            s_d       = in_word;
            s_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data entries are reset as well as the valid bits
            // because the ALU inputs must read zero while in reset.
            m_q       <= '0;
            s_q       <= '0;
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge state computed above.
            m_q       <= m_d;
            s_q       <= s_d;
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            in_ready  <= !s_valid_d;
        end
    end

    assign out_valid       = m_valid_q;
    assign out_opcode      = m_q.opcode;
    assign out_rs_content  = m_q.rs_content;
    assign out_rt_content  = m_q.rt_content;
    assign out_shamt       = m_q.shamt;
    assign out_alu_control = m_q.alu_control;
    assign out_immediate   = m_q.immediate;

endmodule
